// File: rtl/uart_tx_arb.sv
// Round-robin arbiter granting one of four byte-stream requesters a shared UART transmitter per packet.
// Optional macro UART_TX_ARB_HEADER_EN prefixes each packet with a channel header byte.
module uart_tx_arb #(
  parameter int          NUM_CH   = 4,
  parameter logic [7:0]  HDR_BASE = 8'hA0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [8*NUM_CH-1:0]   req_data,
  input  logic [NUM_CH-1:0]     req_last,
  output logic [NUM_CH-1:0]     req_ready,
  output logic                  uart_tx_start,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_tx_busy,
  output logic [1:0]            grant_ch,
  output logic                  grant_active
);

  typedef enum logic [2:0] {IDLE, HDR, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  grant_ch_reg, grant_ch_next;
  logic [1:0]  last_grant_reg, last_grant_next;
  logic        grant_active_reg, grant_active_next;
  logic        tx_start_reg, tx_start_next;
  logic [7:0]  tx_data_reg, tx_data_next;
  logic        last_reg, last_next;

  // Candidates in priority order: cand_ch[0] is the channel right after the last grant.
  logic [1:0]        cand_ch [NUM_CH];
  logic [NUM_CH-1:0] cand_valid;
  logic              pick_any;
  logic [1:0]        pick_ch;

  logic        sel_valid;
  logic [7:0]  sel_data;
  logic        sel_last;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign cand_ch[gi]    = last_grant_reg + 2'(gi + 1);
      assign cand_valid[gi] = req_valid[cand_ch[gi]];
    end
  endgenerate

  always_comb begin
    pick_any = |cand_valid;
    pick_ch  = cand_ch[0];
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cand_valid[k]) pick_ch = cand_ch[k];
    end
  end

  assign sel_valid = req_valid[grant_ch_reg];
  assign sel_data  = req_data[{grant_ch_reg, 3'b000} +: 8];
  assign sel_last  = req_last[grant_ch_reg];

  // Only the granted channel may see ready, and only while a payload byte can be taken.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign req_ready[gi] = !rst && (state_reg == SEND) &&
                             (grant_ch_reg == 2'(gi)) && req_valid[gi];
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    grant_ch_next     = grant_ch_reg;
    last_grant_next   = last_grant_reg;
    grant_active_next = grant_active_reg;
    tx_start_next     = 1'b0;
    tx_data_next      = tx_data_reg;
    last_next         = last_reg;
    case (state_reg)
      IDLE: begin
        grant_active_next = 1'b0;
        if (!uart_tx_busy && pick_any) begin
          grant_ch_next     = pick_ch;
          grant_active_next = 1'b1;
`ifdef UART_TX_ARB_HEADER_EN
          state_next        = HDR;
`else
          state_next        = SEND;
`endif
        end
      end
      HDR: begin
        tx_start_next = 1'b1;
        tx_data_next  = {HDR_BASE[7:4], 2'b00, grant_ch_reg};
        last_next     = 1'b0;
        state_next    = WAIT_HI;
      end
      SEND: begin
        if (sel_valid) begin
          tx_start_next = 1'b1;
          tx_data_next  = sel_data;
          last_next     = sel_last;
          state_next    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (uart_tx_busy) state_next = WAIT_LO;
      end
      WAIT_LO: begin
        if (!uart_tx_busy) begin
          if (last_reg) begin
            state_next        = IDLE;
            last_grant_next   = grant_ch_reg;
            grant_active_next = 1'b0;
          end else begin
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      grant_ch_reg     <= 2'd0;
      last_grant_reg   <= 2'd3;
      grant_active_reg <= 1'b0;
      tx_start_reg     <= 1'b0;
      tx_data_reg      <= 8'h00;
      last_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      grant_ch_reg     <= grant_ch_next;
      last_grant_reg   <= last_grant_next;
      grant_active_reg <= grant_active_next;
      tx_start_reg     <= tx_start_next;
      tx_data_reg      <= tx_data_next;
      last_reg         <= last_next;
    end
  end

  assign uart_tx_start = tx_start_reg;
  assign uart_tx_data  = tx_data_reg;
  assign grant_ch      = grant_ch_reg;
  assign grant_active  = grant_active_reg;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a 10-cycle-per-byte transmitter busy model.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic [1:0]  grant_ch;
  logic        grant_active;

  int busy_cnt = 0;
  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arb dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .grant_ch      (grant_ch),
    .grant_active  (grant_active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after start and lasts 10 cycles.
  always @(posedge clk) begin
    if (uart_tx_start === 1'b1) busy_cnt <= 10;
    else if (busy_cnt > 0)      busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (uart_tx_start === 1'b1) chk("start_vs_busy", uart_tx_busy, 0);
  end

  task automatic set_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
    req_valid[ch]        = v;
    req_data[ch*8 +: 8]  = d;
    req_last[ch]         = l;
  endtask

  task automatic wait_start(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (uart_tx_start !== 1'b1 && i < 60) begin
      @(negedge clk);
      i++;
    end
    chk(tag, uart_tx_start, 1);
  endtask

  task automatic wait_fall(input string tag);
    int i;
    i = 0;
    while (uart_tx_busy !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_rise"}, uart_tx_busy, 1);
    while (uart_tx_busy !== 1'b0 && i < 80) begin
      @(negedge clk);
      i++;
    end
    chk(tag, uart_tx_busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_start", uart_tx_start, 0);
    chk("rst_data",  uart_tx_data, 0);
    chk("rst_gch",   grant_ch, 0);
    chk("rst_gact",  grant_active, 0);
    chk("rst_ready", req_ready, 0);

`ifdef UART_TX_ARB_HEADER_EN
    set_ch(3, 1'b1, 8'h7E, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    chk("hdr_grant", {grant_active, grant_ch}, 3'b111);
    chk("hdr_ready_hdr", req_ready, 0);
    @(negedge clk);
    chk("hdr_start", uart_tx_start, 1);
    chk("hdr_byte", uart_tx_data, 8'hA3);
    wait_start("hdr_pay_start");
    chk("hdr_pay_data", uart_tx_data, 8'h7E);
    set_ch(3, 1'b0, 8'h00, 1'b0);
    wait_fall("hdr_fall");
    @(negedge clk);
    chk("hdr_release", grant_active, 0);
`else
    // Two-byte packet on channel 0
    set_ch(0, 1'b1, 8'h55, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("s1_grant", {grant_active, grant_ch}, 3'b100);
    chk("s1_ready", req_ready, 4'b0001);
    chk("s1_nostart", uart_tx_start, 0);
    @(negedge clk);
    chk("s1_start55", uart_tx_start, 1);
    chk("s1_data55", uart_tx_data, 8'h55);
    chk("s1_ready_wait", req_ready, 0);
    set_ch(0, 1'b1, 8'hAA, 1'b1);
    wait_start("s1_startAA");
    chk("s1_dataAA", uart_tx_data, 8'hAA);
    set_ch(0, 1'b0, 8'h00, 1'b0);
    wait_fall("s1_fall");
    chk("s1_hold_at_fall", grant_active, 1);
    @(negedge clk);
    chk("s1_release", grant_active, 0);

    // Rotating priority: ch1 and ch3 together, then ch1 re-requests
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_ch(1, 1'b1, 8'h11, 1'b1);
    set_ch(3, 1'b1, 8'h33, 1'b1);
    @(negedge clk);
    chk("s2_first_ch1", {grant_active, grant_ch}, 3'b101);
    chk("s2_ready1", req_ready, 4'b0010);
    @(negedge clk);
    chk("s2_start11", uart_tx_start, 1);
    chk("s2_data11", uart_tx_data, 8'h11);
    set_ch(1, 1'b0, 8'h00, 1'b0);
    wait_fall("s2_fall1");
    set_ch(1, 1'b1, 8'h12, 1'b1);
    @(negedge clk);
    chk("s2_idle", grant_active, 0);
    @(negedge clk);
    chk("s2_ch3_wins", {grant_active, grant_ch}, 3'b111);
    chk("s2_ready3", req_ready, 4'b1000);
    @(negedge clk);
    chk("s2_data33", uart_tx_data, 8'h33);
    set_ch(3, 1'b0, 8'h00, 1'b0);
    wait_fall("s2_fall3");
    @(negedge clk);
    @(negedge clk);
    chk("s2_then_ch1", {grant_active, grant_ch}, 3'b101);
    @(negedge clk);
    chk("s2_data12", uart_tx_data, 8'h12);
    set_ch(1, 1'b0, 8'h00, 1'b0);
    wait_fall("s2_fall1b");
    @(negedge clk);

    // Channel 2 stalls mid-packet while channel 0 waits
    set_ch(2, 1'b1, 8'h21, 1'b0);
    @(negedge clk);
    chk("s3_grant2", {grant_active, grant_ch}, 3'b110);
    @(negedge clk);
    chk("s3_data21", uart_tx_data, 8'h21);
    set_ch(2, 1'b0, 8'h00, 1'b0);
    set_ch(0, 1'b1, 8'h01, 1'b1);
    wait_fall("s3_fall");
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      chk("s3_stall", {uart_tx_start, req_ready, grant_active, grant_ch}, 8'b0_0000_1_10);
      @(negedge clk);
    end
    set_ch(2, 1'b1, 8'h22, 1'b1);
    @(negedge clk);
    chk("s3_start22", uart_tx_start, 1);
    chk("s3_data22", uart_tx_data, 8'h22);
    set_ch(2, 1'b0, 8'h00, 1'b0);
    wait_fall("s3_fall2");
    @(negedge clk);
    @(negedge clk);
    chk("s3_ch0", {grant_active, grant_ch}, 3'b100);
    chk("s3_ready0", req_ready, 4'b0001);
    @(negedge clk);
    chk("s3_data01", uart_tx_data, 8'h01);
    set_ch(0, 1'b0, 8'h00, 1'b0);
    wait_fall("s3_fall0");
    @(negedge clk);

    // Reset while waiting for busy to fall
    set_ch(0, 1'b1, 8'h5A, 1'b0);
    @(negedge clk);
    chk("s4_grant", {grant_active, grant_ch}, 3'b100);
    @(negedge clk);
    chk("s4_data5A", uart_tx_data, 8'h5A);
    for (int i = 0; i < 5 && uart_tx_busy !== 1'b1; i++) @(negedge clk);
    chk("s4_busy_hi", uart_tx_busy, 1);
    @(negedge clk);
    rst = 1'b1;
    chk("s4_ready_rst", req_ready, 0);
    @(negedge clk);
    chk("s4_all_zero", {uart_tx_start, uart_tx_data, grant_ch, grant_active, req_ready}, 0);
    rst = 1'b0;
    set_ch(0, 1'b1, 8'h5B, 1'b1);
    for (int i = 0; i < 20 && uart_tx_busy === 1'b1; i++) begin
      chk("s4_no_grant", {grant_active, req_ready}, 0);
      @(negedge clk);
    end
    chk("s4_busy_lo", uart_tx_busy, 0);
    chk("s4_still_idle", grant_active, 0);
    @(negedge clk);
    chk("s4_regrant", {grant_active, grant_ch}, 3'b100);
    @(negedge clk);
    chk("s4_start5B", uart_tx_start, 1);
    chk("s4_data5B", uart_tx_data, 8'h5B);
    set_ch(0, 1'b0, 8'h00, 1'b0);
    wait_fall("s4_fall");
    @(negedge clk);
    chk("s4_release", grant_active, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_CH, default 4, meaning number of requester channels (fixed at 4 for this revision).
REQ-002 Parameter HDR_BASE, default 8'hA0, meaning upper nibble of the channel header byte (used only when the Configuration macro is defined).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  4  per-channel byte-valid.
REQ-006 req_data  input  32  per-channel byte; channel i occupies bits [8i+7:8i].
REQ-007 req_last  input  4  per-channel end-of-packet flag, qualified by req_valid.
REQ-008 req_ready  output  4  per-channel accept strobe; a byte transfers when valid and ready are both high.
REQ-009 uart_tx_start  output  1  one-cycle start pulse to the shared transmitter.
REQ-010 uart_tx_data  output  8  byte to transmit; registered; stable while uart_tx_start is high.
REQ-011 uart_tx_busy  input  1  transmitter busy; rises the cycle after a start pulse and falls when the stop bits finish.
REQ-012 grant_ch  output  2  index of the channel currently owning the transmitter.
REQ-013 grant_active  output  1  high while a packet grant is held.

Function
REQ-014 The FSM SHALL have states IDLE, HDR, SEND, WAIT_HI and WAIT_LO.
REQ-015 IDLE: when uart_tx_busy is low and any req_valid bit is set, the block SHALL grant the first valid channel searching upward, with wrap, from last_grant+1, then register grant_ch, set grant_active, and go to HDR (macro defined) or SEND (macro undefined).
REQ-016 IDLE with no valid requester or with busy high: the block SHALL remain in IDLE with grant_active=0.
REQ-017 SEND: req_ready[grant_ch] SHALL equal req_valid[grant_ch], combinationally; all other req_ready bits SHALL be 0 in every state.
REQ-018 SEND transfer: the block SHALL register req_data and req_last of the granted channel, drive uart_tx_start=1 on the next cycle with that byte, and go to WAIT_HI.
REQ-019 SEND with the granted valid low: the block SHALL hold the grant indefinitely, with no timeout and no preemption.
REQ-020 WAIT_HI: the block SHALL go to WAIT_LO on the first cycle uart_tx_busy=1.
REQ-021 WAIT_LO: on the first cycle uart_tx_busy=0, the block SHALL go to IDLE if the sent byte was last (update last_grant, clear grant_active), else return to SEND.
REQ-022 HDR: the block SHALL pulse uart_tx_start with {HDR_BASE[7:4], 2'b00, grant_ch}, then go to WAIT_HI with the last flag cleared.
REQ-023 uart_tx_start SHALL be high for exactly one cycle per byte and never while uart_tx_busy is high.
REQ-024 Minimum latency: req_valid rising in IDLE to uart_tx_start SHALL be 2 cycles (macro undefined): grant cycle, then accept cycle.
REQ-025 Simultaneous requests: at most one channel SHALL be granted; the rotating priority SHALL guarantee each waiting channel a grant within 3 packets.
REQ-026 A single-byte packet (req_last=1 on the first byte) SHALL release the grant after that byte's stop bits.

Reset
REQ-027 Under rst: state=IDLE, uart_tx_start=0, uart_tx_data=0, grant_ch=0, grant_active=0, req_ready=0, last_grant=3, so channel 0 has first priority.
REQ-028 Reset mid-packet: the block SHALL abandon the packet, with no further req_ready to that channel.
REQ-029 After reset, a byte already in flight in the transmitter SHALL complete; IDLE SHALL not grant until uart_tx_busy is low.

Configuration
REQ-030 Macro UART_TX_ARB_HEADER_EN: when defined, the HDR state SHALL send one header byte before each packet; when undefined, IDLE SHALL go directly to SEND and HDR SHALL be unreachable.

Verification
REQ-031 Ch0 sends {0x55, 0xAA(last)} with busy modelled as 10 cycles per byte -> two start pulses with data 0x55 then 0xAA, grant released after the second busy fall; 0x55 start 2 cycles after valid.
REQ-032 Ch1 and ch3 valid in the same cycle after reset -> ch1 is granted first; after its packet, ch3 is granted; ch1 is requested again at the same time -> ch3 wins.
REQ-033 Ch2 stalls valid for 50 cycles mid-packet while ch0 is valid -> no start pulses, ch0 req_ready stays 0, grant_ch=2 throughout.
REQ-034 rst asserted in WAIT_LO with busy=1 -> all outputs 0 next cycle; a new ch0 request is not granted until busy falls.
REQ-035 With UART_TX_ARB_HEADER_EN defined, ch3 sends 0x7E(last) -> start pulses carry 0xA3 then 0x7E.
REQ-036 Across all scenarios, the bench SHALL assert that uart_tx_start never coincides with uart_tx_busy=1.
